// File: rtl/prj1_host_pkg.sv
// prj1_host_pkg
// Shared definitions for the FFT/NTT host driver: FSM state encoding,
// command opcode, control register address and terminal beat counts.
// Optional feature macro used by the driver: PRJ1_HOST_TLAST_CHECK_EN.
package prj1_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_COLLECT,
    ST_POLL_AR,
    ST_POLL_R,
    ST_POLL_GAP,
    ST_RELEASE,
    ST_DONE
  } state_e;

  localparam logic [1:0]  CMD_OPCODE    = 2'b01;
  localparam logic [11:0] REG_CTRL_ADDR = 12'h000;
  localparam logic [11:0] FFT_BEATS     = 12'd2047;
  localparam logic [11:0] NTT_BEATS     = 12'd1023;

  // Terminal beat index for a job; mode[1] selects NTT.
  function automatic logic [11:0] term_count(input logic is_ntt);
    return is_ntt ? NTT_BEATS : FFT_BEATS;
  endfunction

endpackage

// File: rtl/prj1_host_axil.sv
// prj1_host_axil
// Single-transaction AXI-Lite master. A one-cycle i_req starts either a
// read (i_we=0) or a write (i_we=1) whose AW and W channels are raised
// together and dropped together on the first cycle both are accepted.
// All AXI-Lite outputs are registered; o_ack pulses in the cycle the
// transaction completes (R handshake or joint AW/W handshake) and
// o_rdata carries the read word in that cycle.
// Ports:
//   axi_clk, rst           clock, asynchronous active-high reset
//   i_req, i_we            start request / write select
//   i_addr, i_wdata        transaction address / write data
//   o_ack, o_rdata         completion pulse / read data
//   o_aw*, o_w*, i_awready, i_wready   write address + data channels
//   o_ar*, i_arready, i_rvalid, i_rdata, o_rready   read channels
module prj1_host_axil #(
  parameter int pDATA_WIDTH = 32,
  parameter int pADDR_WIDTH = 12
) (
  input  logic                       axi_clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic                       i_we,
  input  logic [pADDR_WIDTH-1:0]     i_addr,
  input  logic [pDATA_WIDTH-1:0]     i_wdata,
  output logic                       o_ack,
  output logic [pDATA_WIDTH-1:0]     o_rdata,
  output logic                       o_awvalid,
  output logic [pADDR_WIDTH-1:0]     o_awaddr,
  input  logic                       i_awready,
  output logic                       o_wvalid,
  output logic [pDATA_WIDTH-1:0]     o_wdata,
  output logic [pDATA_WIDTH/8-1:0]   o_wstrb,
  input  logic                       i_wready,
  output logic                       o_arvalid,
  output logic [pADDR_WIDTH-1:0]     o_araddr,
  input  logic                       i_arready,
  input  logic                       i_rvalid,
  input  logic [pDATA_WIDTH-1:0]     i_rdata,
  output logic                       o_rready
);

  logic                     r_awvalid;
  logic                     r_wvalid;
  logic [pADDR_WIDTH-1:0]   r_awaddr;
  logic [pDATA_WIDTH-1:0]   r_wdata;
  logic [pDATA_WIDTH/8-1:0] r_wstrb;
  logic                     r_arvalid;
  logic [pADDR_WIDTH-1:0]   r_araddr;
  logic                     r_rready;
  logic                     w_wr_hs;
  logic                     w_rd_hs;

  // The responder only accepts AW and W in the same cycle.
  assign w_wr_hs = r_awvalid && r_wvalid && i_awready && i_wready;
  assign w_rd_hs = r_rready && i_rvalid;

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_rready  <= 1'b0;
    end else begin
      if (i_req) begin
        if (i_we) begin
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_awaddr  <= i_addr;
          r_wdata   <= i_wdata;
          r_wstrb   <= '1;
        end else begin
          r_arvalid <= 1'b1;
          r_araddr  <= i_addr;
        end
      end
      if (r_arvalid && i_arready) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (w_rd_hs) begin
        r_rready <= 1'b0;
      end
      if (w_wr_hs) begin
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
      end
    end
  end

  assign o_ack     = w_rd_hs || w_wr_hs;
  assign o_rdata   = i_rdata;
  assign o_awvalid = r_awvalid;
  assign o_awaddr  = r_awaddr;
  assign o_wvalid  = r_wvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  assign o_arvalid = r_arvalid;
  assign o_araddr  = r_araddr;
  assign o_rready  = r_rready;

endmodule

// File: rtl/prj1_host_driver.sv
// prj1_host_driver
// Host-side initiator for the FFT/NTT user project. One start runs a job:
// command beat + payload out on ss_*, result in on sm_* (forwarded to
// dst_*), AXI-Lite polling of the control register until bit 0 is set,
// then a write of 1 to release the project.
// Optional feature: define PRJ1_HOST_TLAST_CHECK_EN to compare sm_tlast
// against the terminal beat during COLLECT and flag mismatches on err.
// Ports:
//   axi_clk, rst         clock, asynchronous active-high reset
//   start, mode          job request (IDLE only) and mode (mode[1]=NTT)
//   busy, done, err      job in flight / end pulse / sticky error
//   src_*  -> ss_*       payload path into the user project
//   sm_*   -> dst_*      result path out of the user project
//   aw*, w*, ar*, r*     AXI-Lite master towards the user project
import prj1_host_pkg::*;

module prj1_host_driver #(
  parameter int pDATA_WIDTH = 32,
  parameter int pADDR_WIDTH = 12,
  parameter int pPOLL_GAP   = 16
) (
  input  logic                     axi_clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  input  logic                     src_tvalid,
  output logic                     src_tready,
  input  logic [pDATA_WIDTH-1:0]   src_tdata,
  output logic                     ss_tvalid,
  input  logic                     ss_tready,
  output logic [pDATA_WIDTH-1:0]   ss_tdata,
  output logic                     ss_tlast,
  input  logic                     sm_tvalid,
  output logic                     sm_tready,
  input  logic [pDATA_WIDTH-1:0]   sm_tdata,
  input  logic                     sm_tlast,
  output logic                     dst_tvalid,
  input  logic                     dst_tready,
  output logic [pDATA_WIDTH-1:0]   dst_tdata,
  output logic                     awvalid,
  output logic [pADDR_WIDTH-1:0]   awaddr,
  input  logic                     awready,
  output logic                     wvalid,
  output logic [pDATA_WIDTH-1:0]   wdata,
  output logic [pDATA_WIDTH/8-1:0] wstrb,
  input  logic                     wready,
  output logic                     arvalid,
  output logic [pADDR_WIDTH-1:0]   araddr,
  input  logic                     arready,
  input  logic                     rvalid,
  input  logic [pDATA_WIDTH-1:0]   rdata,
  output logic                     rready
);

  localparam int GAP_W = $clog2(pPOLL_GAP) + 1;

  state_e                 r_state;
  logic [1:0]             r_mode;
  logic [11:0]            r_cnt;
  logic [GAP_W-1:0]       r_gap;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  logic                   w_term;
  logic                   w_data_hs;
  logic                   w_coll_hs;
  logic                   w_coll_end;
  logic                   w_coll_err;
  logic                   w_req;
  logic                   w_we;
  logic                   w_ack;
  logic [pDATA_WIDTH-1:0] w_rdata;
  logic                   w_unused;

  assign w_term    = (r_cnt == term_count(r_mode[1]));
  assign w_data_hs = (r_state == ST_DATA) && src_tvalid && ss_tready;
  assign w_coll_hs = (r_state == ST_COLLECT) && sm_tvalid && dst_tready;

  // Sink for inputs the FSM does not consume in every build.
  assign w_unused = &{1'b0, sm_tlast, w_rdata[pDATA_WIDTH-1:1]};

  // End-of-collect decision; with the tlast check an early tlast also ends
  // the phase, and a missing tlast on the terminal beat is only flagged.
  always_comb begin
    w_coll_end = 1'b0;
    w_coll_err = 1'b0;
    if (w_coll_hs) begin
`ifdef PRJ1_HOST_TLAST_CHECK_EN
      if (w_term) begin
        w_coll_end = 1'b1;
        w_coll_err = !sm_tlast;
      end else if (sm_tlast) begin
        w_coll_end = 1'b1;
        w_coll_err = 1'b1;
      end
`else
      w_coll_end = w_term;
`endif
    end
  end

  // AXI-Lite requests are issued on the transition into POLL_AR/RELEASE so
  // the registered valids are already high in the first cycle of the state.
  always_comb begin
    w_req = 1'b0;
    w_we  = 1'b0;
    case (r_state)
      ST_COLLECT:  w_req = w_coll_end;
      ST_POLL_R: begin
        if (w_ack && w_rdata[0]) begin
          w_req = 1'b1;
          w_we  = 1'b1;
        end
      end
      ST_POLL_GAP: w_req = (r_gap == '0);
      default:     w_req = 1'b0;
    endcase
  end

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= 2'b00;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (ss_tready) r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_data_hs) begin
            if (w_term) begin
              r_cnt   <= '0;
              r_state <= ST_COLLECT;
            end else begin
              r_cnt <= r_cnt + 12'd1;
            end
          end
        end
        ST_COLLECT: begin
          if (w_coll_err) r_err <= 1'b1;
          if (w_coll_end) begin
            r_state <= ST_POLL_AR;
          end else if (w_coll_hs) begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
        ST_POLL_AR: begin
          if (arready) r_state <= ST_POLL_R;
        end
        ST_POLL_R: begin
          if (w_ack) begin
            if (w_rdata[0]) begin
              r_state <= ST_RELEASE;
            end else begin
              r_gap   <= GAP_W'(pPOLL_GAP - 1);
              r_state <= ST_POLL_GAP;
            end
          end
        end
        ST_POLL_GAP: begin
          if (r_gap == '0) r_state <= ST_POLL_AR;
          else r_gap <= r_gap - GAP_W'(1);
        end
        ST_RELEASE: begin
          if (w_ack) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stream paths: registered state selects, data passes straight through.
  always_comb begin
    src_tready = 1'b0;
    ss_tvalid  = 1'b0;
    ss_tdata   = '0;
    ss_tlast   = 1'b0;
    sm_tready  = 1'b0;
    dst_tvalid = 1'b0;
    dst_tdata  = '0;
    case (r_state)
      ST_CMD: begin
        ss_tvalid = 1'b1;
        ss_tdata  = {{(pDATA_WIDTH-4){1'b0}}, CMD_OPCODE, r_mode};
      end
      ST_DATA: begin
        ss_tvalid  = src_tvalid;
        src_tready = ss_tready;
        ss_tdata   = src_tdata;
        ss_tlast   = w_term;
      end
      ST_COLLECT: begin
        dst_tvalid = sm_tvalid;
        sm_tready  = dst_tready;
        dst_tdata  = sm_tdata;
      end
      default: ss_tvalid = 1'b0;
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

  prj1_host_axil #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pADDR_WIDTH (pADDR_WIDTH)
  ) u_axil (
    .axi_clk   (axi_clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_we      (w_we),
    .i_addr    (pADDR_WIDTH'(REG_CTRL_ADDR)),
    .i_wdata   (pDATA_WIDTH'(1)),
    .o_ack     (w_ack),
    .o_rdata   (w_rdata),
    .o_awvalid (awvalid),
    .o_awaddr  (awaddr),
    .i_awready (awready),
    .o_wvalid  (wvalid),
    .o_wdata   (wdata),
    .o_wstrb   (wstrb),
    .i_wready  (wready),
    .o_arvalid (arvalid),
    .o_araddr  (araddr),
    .i_arready (arready),
    .i_rvalid  (rvalid),
    .i_rdata   (rdata),
    .o_rready  (rready)
  );

endmodule

// File: doc/prj1_host_driver.md
# prj1_host_driver

Host-side initiator for the FFT/NTT user project. One `start` runs a full job:
- send the command beat and input payload on the user project's slave stream;
- collect the result stream;
- poll the project's status register over AXI-Lite until it reports its RESET state;
- write the release bit.

It sits on the FSIC side, in place of the firmware/DMA sequence. It is the opposite end of the `ss_*`, `sm_*` and AXI-Lite ports of the user project.

## Interface
Parameters:
- pDATA_WIDTH, 32, stream and AXI-Lite data width
- pADDR_WIDTH, 12, AXI-Lite address width
- pPOLL_GAP, 16, idle cycles between status polls (minimum 1)

Ports:
- axi_clk  in  1  sole clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  job request; sampled only in IDLE
- mode  in  2  job mode; mode[1]=0 selects FFT (2048 beats each way), mode[1]=1 selects NTT (1024 beats each way)
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky; cleared on next accepted start
- src_tvalid / src_tready / src_tdata  in / out / 32  input payload from upstream
- ss_tvalid / ss_tready / ss_tdata / ss_tlast  out / in / 32 / out  to user project
- sm_tvalid / sm_tready / sm_tdata / sm_tlast  in / out / 32 / in  from user project
- dst_tvalid / dst_tready / dst_tdata  out / in / 32  result to downstream
- awvalid, awaddr[11:0], wvalid, wdata[31:0], wstrb[3:0]  out;  awready, wready  in
- arvalid, araddr[11:0], rready  out;  arready, rvalid, rdata[31:0]  in

## Operation
States: IDLE, CMD, DATA, COLLECT, POLL_AR, POLL_R, POLL_GAP, RELEASE, DONE.
- **IDLE**: on `start`, latch `mode`, clear `err` and the 12-bit beat counter, then go to CMD. `start` is ignored in every other state.
- **CMD**: hold `ss_tvalid`=1 with `ss_tdata` = {28'b0, 2'b01, mode}. On `ss_tready`, go to DATA.
- **DATA**: combinational pass-through.
  - `ss_tvalid` = `src_tvalid`, `src_tready` = `ss_tready`, `ss_tdata` = `src_tdata`.
  - Count each handshake.
  - `ss_tlast` = 1 on beat 2047 (FFT) or 1023 (NTT).
  - After the last handshake, go to COLLECT.
- **COLLECT**: pass-through.
  - `dst_tvalid` = `sm_tvalid`, `sm_tready` = `dst_tready`, `dst_tdata` = `sm_tdata`.
  - Count handshakes from 0; the expected total is 2048 or 1024.
  - After the final beat, go to POLL_AR.
- **POLL_AR**: `arvalid`=1, `araddr`=12'h000. On `arready`, go to POLL_R.
- **POLL_R**: `rready`=1. On `rvalid`:
  - if `rdata[0]`=1, go to RELEASE;
  - otherwise go to POLL_GAP.
- **POLL_GAP**: wait pPOLL_GAP cycles, then go to POLL_AR.
- **RELEASE**: `awvalid`=`wvalid`=1 together, with `awaddr`=12'h000, `wdata`=32'h1, `wstrb`=4'hF.
  - Both stay high until a cycle in which `awready`&&`wready` are both 1. The responder accepts only simultaneous AW/W.
  - Then go to DONE.
- **DONE**: pulse `done`, go to IDLE.

Boundary rules:
- Counters are 12-bit. The terminal compare is on count value 2047 or 1023; there is no wrap.
- `rst` asserted mid-job: immediate return to IDLE. All valids drop and the count is lost. The user project must be reset separately.

## Timing
- Reset values: all outputs 0, including `busy`, `done`, `err`, every valid/ready, all data and address buses.
- `start` → `ss_tvalid` for CMD: 1 cycle (registered).
- DATA and COLLECT paths: zero added latency, combinational through.
- All AXI-Lite outputs are registered.
- `done` follows the RELEASE handshake by exactly 1 cycle. `busy` falls in the same cycle `done` pulses.
- Minimum total job length: 1 + N + N + 2 + 1 + 1 cycles, for an immediate ready `rdata[0]`.

## Configuration
`PRJ1_HOST_TLAST_CHECK_EN`
- **Defined**: in COLLECT, `sm_tlast` is compared against the terminal beat.
  - `sm_tlast`=1 early sets `err` and ends COLLECT immediately.
  - Missing `sm_tlast` on the terminal beat sets `err` but continues to POLL.
- **Undefined**: `sm_tlast` is ignored, COLLECT ends on count only, and `err` stays 0.

## Structure
- Package `prj1_host_pkg`:
  - state enum;
  - CMD_OPCODE = 2'b01;
  - REG_CTRL_ADDR = 12'h000;
  - FFT_BEATS = 12'd2047, NTT_BEATS = 12'd1023 (terminal counts).
- Sub-module `prj1_host_axil`: single-transaction AXI-Lite master.
  - Operations: read, and write with joint AW/W.
  - Signals: `req`, `we`, `addr`, `wdata`, `ack`, `rdata`.
  - The top FSM drives the POLL/RELEASE states through it.

## Test plan
- **FFT job, always ready**: mode=2'b00, 2048 src beats, `sm_tlast` on beat 2047, `rdata`=1 on first poll → `ss_tdata` first beat 32'h4, `ss_tlast` on beat 2047, write to 0x000 data 1, `done` one cycle, `err`=0.
- **NTT job with backpressure**: mode=2'b11, `ss_tready` and `dst_tready` toggled randomly → exactly 1024 beats each way, no lost or duplicated data, `ss_tlast` on beat 1023.
- **Polling**: `rdata`=0 for 3 reads, then 1 → 4 AR handshakes spaced ≥pPOLL_GAP cycles, then exactly one write.
- **Split AW/W ready**: `awready` high one cycle with `wready` low, then both high later → `awvalid`/`wvalid` stay high until the joint cycle, single write.
- **Macro on, early `sm_tlast`**: `sm_tlast` at beat 500 → `err`=1, polling starts; the next `start` clears `err`.
- **Mid-DATA reset**: `rst` pulsed at beat 100 → all outputs 0 the same cycle, `busy`=0, and a new `start` emits the CMD beat again.
